// File: rtl/arb16_mux_ctrl.sv
// Round-robin arbiter/sequencer for the shared 16:1 bit-select mux: one-hot grant, binary select.
// Optional forced release after TIMEOUT grant cycles is compiled in with `define ARB_TIMEOUT_EN.
module arb16_mux_ctrl #(
  parameter int TIMEOUT = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_req,
  input  logic        i_done,
  output logic [15:0] o_grant,
  output logic [3:0]  o_sel,
  output logic        o_busy,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

  state_t      r_state;
  logic [3:0]  r_ptr;
  logic [3:0]  r_sel;
  logic [15:0] r_grant;
  logic        r_busy;

  logic        w_found;
  logic [3:0]  w_win;
  logic [3:0]  w_idx;
  logic        w_to;
  logic        w_rel;

  // First set request scanning upward from the pointer, wrapping 15->0.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int i = 0; i < 16; i++) begin
      w_idx = r_ptr + 4'(i);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_timeout;

  assign w_to      = (r_cnt == 8'(TIMEOUT - 1));
  assign o_timeout = r_timeout;

  // Counter is zeroed while idle so it starts at 0 on every new grant.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= (r_state == GRANT) && w_to;
      if (r_state == IDLE)
        r_cnt <= 8'd0;
      else if (r_state == GRANT && !w_rel && r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  assign w_to      = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign w_rel = i_done || !i_req[r_sel] || w_to;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_ptr   <= 4'd0;
      r_sel   <= 4'd0;
      r_grant <= 16'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= 16'd1 << w_win;
            r_sel   <= w_win;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_rel) begin
            r_grant <= 16'd0;
            r_busy  <= 1'b0;
            r_ptr   <= r_sel + 4'd1;
            r_state <= GAP;
          end
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_grant = r_grant;
  assign o_sel   = r_sel;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_arb16_mux_ctrl.sv
// Directed bench for arb16_mux_ctrl: ownership-level reference model checked every cycle
// plus hand-computed expectations for idle, wrap-around, fairness, timeout and async reset.
module tb_arb16_mux_ctrl;
  localparam int TIMEOUT = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] req = 16'h0;
  logic        done = 1'b0;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic        busy;
  logic        tmo;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  arb16_mux_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_done(done),
    .o_grant(grant), .o_sel(sel), .o_busy(busy), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  // Model: who owns the path (-1 = nobody), how long it has held it, and whose turn is next.
  int m_owner = -1;
  bit m_gap   = 1'b0;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_sel   = 0;
  bit m_to    = 1'b0;

  function automatic int first_from(int p, logic [15:0] r);
    for (int k = 0; k < 16; k++)
      if (r[(p + k) % 16]) return (p + k) % 16;
    return -1;
  endfunction

  function automatic logic [15:0] exp_grant(int o);
    return (o >= 0) ? (16'h1 << o) : 16'h0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1; m_gap <= 1'b0; m_ptr <= 0; m_hold <= 0; m_sel <= 0; m_to <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (m_owner >= 0) begin
        if (done || !req[m_owner] || (TO_EN && m_hold >= TIMEOUT)) begin
          m_ptr   <= (m_owner + 1) % 16;
          m_owner <= -1;
          m_gap   <= 1'b1;
          m_to    <= TO_EN && m_hold >= TIMEOUT;
        end else begin
          m_hold <= m_hold + 1;
        end
      end else if (m_gap) begin
        m_gap <= 1'b0;
      end else if (req != 16'h0) begin
        m_owner <= first_from(m_ptr, req);
        m_sel   <= first_from(m_ptr, req);
        m_hold  <= 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_grant",   32'(grant), 32'(exp_grant(m_owner)));
      chk("model_sel",     32'(sel),   32'(m_sel));
      chk("model_busy",    32'(busy),  32'(m_owner >= 0));
      chk("model_timeout", 32'(tmo),   32'(m_to));
    end
  end

  task automatic wait_busy(input int lim, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < lim && !ok; k++) begin
      @(negedge clk);
      if (busy) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: no grant within %0d cycles (busy=%0b, expected 1)", nm, lim, busy);
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit gone;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle with no requests
    repeat (10) @(negedge clk);
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_sel",   32'(sel),   32'h0);
    chk("idle_busy",  32'(busy),  32'h0);

    // Single requester 5, released by done
    req = 16'h0020;
    wait_busy(20, "s5_wait");
    chk("s5_grant", 32'(grant), 32'h0020);
    chk("s5_sel",   32'(sel),   32'd5);
    repeat (4) @(negedge clk);
    chk("s5_hold",  32'(grant), 32'h0020);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 16'h0;
    chk("s5_rel_grant", 32'(grant), 32'h0);
    chk("s5_rel_sel",   32'(sel),   32'd5);
    repeat (3) @(negedge clk);
    // ptr is now 6: requester 6 wins over requester 0
    req = 16'h0041;
    wait_busy(10, "ptr6_wait");
    chk("ptr6_sel", 32'(sel), 32'd6);
    req = 16'h0;
    pulse_done();
    repeat (3) @(negedge clk);

    // Fairness with everyone requesting
    sync_reset();
    req = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      wait_busy(10, "rr_wait");
      chk("rr_sel", 32'(sel), 32'(i % 16));
      @(negedge clk);
      pulse_done();
      chk("rr_gap", 32'(grant), 32'h0);
    end
    req = 16'h0;
    repeat (3) @(negedge clk);

    // Wrap-around: previous owner 14 -> ptr 15
    sync_reset();
    req = 16'h4000;
    wait_busy(10, "wrap_pre");
    chk("wrap_pre_sel", 32'(sel), 32'd14);
    req = 16'h0011;
    pulse_done();
    wait_busy(10, "wrap_first_wait");
    chk("wrap_first", 32'(sel), 32'd0);
    pulse_done();
    wait_busy(10, "wrap_second_wait");
    chk("wrap_second", 32'(sel), 32'd4);
    req = 16'h0;
    pulse_done();
    repeat (3) @(negedge clk);

    // ptr 3: requester 4 before requester 0
    req = 16'h0004;
    wait_busy(10, "ptr3_pre");
    chk("ptr3_pre_sel", 32'(sel), 32'd2);
    req = 16'h0011;
    pulse_done();
    wait_busy(10, "ptr3_wait");
    chk("ptr3_first", 32'(sel), 32'd4);
    req = 16'h0;
    pulse_done();
    repeat (3) @(negedge clk);

    // Held request with no done
    req = 16'h8000;
    wait_busy(10, "to_wait");
    chk("to_sel", 32'(sel), 32'd15);
    n = 1;
    gone = 1'b0;
    for (int k = 0; k < 30 && !gone; k++) begin
      @(negedge clk);
      if (!busy) gone = 1'b1;
      else n++;
    end
`ifdef ARB_TIMEOUT_EN
    chk("to_len",   32'(n),   32'd8);
    chk("to_pulse", 32'(tmo), 32'd1);
    wait_busy(5, "to_regrant_wait");
    chk("to_regrant", 32'(sel), 32'd15);
`else
    chk("to_len",   32'(n),   32'd31);
    chk("to_pulse", 32'(tmo), 32'd0);
`endif
    req = 16'h0;
    repeat (4) @(negedge clk);

    // Async reset mid-grant
    req = 16'h0200;
    wait_busy(10, "ar_wait");
    chk("ar_sel", 32'(sel), 32'd9);
    #2 rst = 1'b1;
    #1;
    chk("ar_grant", 32'(grant), 32'h0);
    chk("ar_busy",  32'(busy),  32'h0);
    chk("ar_tmo",   32'(tmo),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 16'h0201;
    wait_busy(10, "ar_post_wait");
    chk("ar_post_sel", 32'(sel), 32'd0);
    req = 16'h0;
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
